osc_sequence_checker: RTL and testbench

//  Downstream monitor for the 2-bit mode oscillator (case 1: 00<->01, case 2: 10<->11; A=1 swaps cases).

---
 rtl/osc_sequence_checker_if.sv | 29 ++
 rtl/osc_sequence_checker.sv | 143 ++++++++++++++
 tb/tb_osc_sequence_checker.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/osc_sequence_checker_if.sv
`default_nettype none
// ==========================================================================
// osc_sequence_checker_if: monitor inputs and status outputs  | Rev 1.0
// ==========================================================================
interface osc_sequence_checker_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic             a_in;
   logic [1:0]       state_in;
   logic             clr_err;
   logic             locked;
   logic             err_pulse;
   logic             err_sticky;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] swap_cnt;
   logic             case_id;

   modport master (
      output en, a_in, state_in, clr_err,
      input  locked, err_pulse, err_sticky, err_cnt, swap_cnt, case_id
   );

   modport slave (
      input  en, a_in, state_in, clr_err,
      output locked, err_pulse, err_sticky, err_cnt, swap_cnt, case_id
   );
endinterface
`default_nettype wire

// File: rtl/osc_sequence_checker.sv
`default_nettype none
// ==========================================================================
// osc_sequence_checker: locks onto the 2-bit mode oscillator, flags deviations | Rev 1.0
// ==========================================================================
module osc_sequence_checker #(
   parameter int LOCK_N = 4,
   parameter int CNT_W  = 8
) (
   input  wire logic               clk,
   input  wire logic               rst,
   osc_sequence_checker_if.slave   bus
);

   localparam int GOOD_W = $clog2(LOCK_N + 1);
   localparam logic [GOOD_W-1:0] c_lock_last = GOOD_W'(LOCK_N - 1);
   localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_ERROR   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [GOOD_W-1:0]  r_good_cnt;
   logic [GOOD_W-1:0]  w_good_next;
   logic [1:0]         r_prev_state;
   logic               r_prev_a;
   logic [1:0]         w_expected;
   logic               w_match;
   logic               w_lock_err;
   logic               w_swap;

   logic               r_locked;
   logic               r_err_pulse;
   logic               r_err_sticky;
   logic [CNT_W-1:0]   r_err_cnt;
   logic [CNT_W-1:0]   r_swap_cnt;
   logic               r_case_id;

   // A=0 toggles within the current case, A=1 swaps case keeping bit 0.
   assign w_expected = r_prev_a ? {~r_prev_state[1], r_prev_state[0]}
                                : { r_prev_state[1], ~r_prev_state[0]};
   assign w_match    = (bus.state_in == w_expected);

   always_comb begin
      w_next_state = r_state;
      w_good_next  = r_good_cnt;
      w_lock_err   = 1'b0;
      w_swap       = 1'b0;
      if (!bus.en) begin
         w_next_state = ST_IDLE;
         w_good_next  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_next_state = ST_ACQUIRE;
               w_good_next  = '0;
            end
            ST_ACQUIRE: begin
               if (w_match) begin
                  if (r_good_cnt == c_lock_last) begin
                     w_next_state = ST_LOCKED;
                     w_good_next  = '0;
                  end else begin
                     w_good_next = r_good_cnt + 1'b1;
                  end
               end else begin
                  w_good_next = '0;
               end
            end
            ST_LOCKED: begin
               if (w_match) begin
                  w_swap = r_prev_a;
               end else begin
                  w_next_state = ST_ERROR;
                  w_lock_err   = 1'b1;
               end
            end
            ST_ERROR: begin
               w_next_state = ST_ACQUIRE;
               w_good_next  = '0;
            end
            default: begin
               w_next_state = ST_IDLE;
               w_good_next  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_good_cnt   <= '0;
         r_prev_state <= 2'b00;
         r_prev_a     <= 1'b0;
         r_locked     <= 1'b0;
         r_err_pulse  <= 1'b0;
         r_err_sticky <= 1'b0;
         r_err_cnt    <= '0;
         r_swap_cnt   <= '0;
         r_case_id    <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_good_cnt  <= w_good_next;
         r_locked    <= (w_next_state == ST_LOCKED);
         r_err_pulse <= w_lock_err;
         r_case_id   <= bus.state_in[1];
         if (bus.en) begin
            r_prev_state <= bus.state_in;
            r_prev_a     <= bus.a_in;
         end
         // A fresh error outranks a simultaneous clear.
         if (w_lock_err) begin
            r_err_sticky <= 1'b1;
            if (bus.clr_err) begin
               r_err_cnt <= c_cnt_one;
            end else if (r_err_cnt != c_cnt_max) begin
               r_err_cnt <= r_err_cnt + 1'b1;
            end
         end else if (bus.clr_err) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
         end
         if (w_swap) begin
            r_swap_cnt <= r_swap_cnt + 1'b1;
         end
      end
   end

   assign bus.locked     = r_locked;
   assign bus.err_pulse  = r_err_pulse;
   assign bus.err_sticky = r_err_sticky;
   assign bus.err_cnt    = r_err_cnt;
   assign bus.swap_cnt   = r_swap_cnt;
   assign bus.case_id    = r_case_id;

endmodule
`default_nettype wire

// File: tb/tb_osc_sequence_checker.sv
`default_nettype none
// ==========================================================================
// tb_osc_sequence_checker: scoreboard bench, 8-bit and 2-bit counter instances | Rev 1.0
// ==========================================================================
module tb_osc_sequence_checker;
   localparam int LOCK_N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, a_in, clr_err;
   logic [1:0] state_in;

   always #5 clk = ~clk;

   osc_sequence_checker_if #(.CNT_W(8)) bus8 ();
   osc_sequence_checker_if #(.CNT_W(2)) bus2 ();

   assign bus8.en = en;  assign bus8.a_in = a_in;  assign bus8.state_in = state_in;  assign bus8.clr_err = clr_err;
   assign bus2.en = en;  assign bus2.a_in = a_in;  assign bus2.state_in = state_in;  assign bus2.clr_err = clr_err;

   osc_sequence_checker #(.LOCK_N(LOCK_N), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   osc_sequence_checker #(.LOCK_N(LOCK_N), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   typedef struct {
      bit locked; bit pulse; bit sticky; int errs; int swaps; bit case_id;
   } exp_t;
   exp_t q[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: whole-history view of the monitor in the spec's own terms.
   bit         m_tracking, m_locked, m_resync, m_sticky, m_case, m_pulse;
   int         m_streak, m_errs, m_swaps;
   logic [1:0] m_prev;
   bit         m_prev_a;

   function automatic void model_reset();
      m_tracking = 0; m_locked = 0; m_resync = 0; m_sticky = 0; m_case = 0; m_pulse = 0;
      m_streak = 0; m_errs = 0; m_swaps = 0; m_prev = 2'b00; m_prev_a = 0;
   endfunction

   function automatic void model_step(input bit e, input bit a, input logic [1:0] st, input bit c);
      bit hit = 0;
      m_case = st[1];
      if (!e) begin
         m_tracking = 0; m_locked = 0; m_resync = 0; m_streak = 0;
      end else begin
         logic [1:0] legal = m_prev_a ? (m_prev ^ 2'b10) : (m_prev ^ 2'b01);
         bit good = (st == legal);
         if (!m_tracking) begin
            m_tracking = 1; m_streak = 0;
         end else if (m_resync) begin
            m_resync = 0; m_streak = 0;
         end else if (m_locked) begin
            if (good) m_swaps += m_prev_a;
            else begin m_locked = 0; m_resync = 1; hit = 1; end
         end else if (good) begin
            m_streak++;
            if (m_streak == LOCK_N) begin m_locked = 1; m_streak = 0; end
         end else begin
            m_streak = 0;
         end
         m_prev = st; m_prev_a = a;
      end
      m_pulse = hit;
      if (hit) begin
         m_sticky = 1; m_errs = c ? 1 : m_errs + 1;
      end else if (c) begin
         m_sticky = 0; m_errs = 0;
      end
   endfunction

   task automatic drive(input bit e, input bit a, input logic [1:0] st, input bit c);
      exp_t x;
      @(negedge clk);
      en = e; a_in = a; state_in = st; clr_err = c;
      @(posedge clk);
      model_step(e, a, st, c);
      x.locked = m_locked; x.pulse = m_pulse; x.sticky = m_sticky;
      x.errs = m_errs; x.swaps = m_swaps; x.case_id = m_case;
      q.push_back(x);
   endtask

   // Oscillator stand-in: follows the legal sequence unless told to glitch.
   logic [1:0] osc;
   bit         osc_a;

   task automatic osc_step(input bit e, input bit a, input bit bad, input bit c);
      logic [1:0] st = osc_a ? (osc ^ 2'b10) : (osc ^ 2'b01);
      if (bad) st = st ^ 2'b10;
      drive(e, a, st, c);
      osc = st; osc_a = a;
   endtask

   task automatic check_zero();
      check("rst_locked8", bus8.locked, 0);     check("rst_locked2", bus2.locked, 0);
      check("rst_pulse8", bus8.err_pulse, 0);   check("rst_pulse2", bus2.err_pulse, 0);
      check("rst_sticky8", bus8.err_sticky, 0); check("rst_sticky2", bus2.err_sticky, 0);
      check("rst_errcnt8", bus8.err_cnt, 0);    check("rst_errcnt2", bus2.err_cnt, 0);
      check("rst_swapcnt8", bus8.swap_cnt, 0);  check("rst_swapcnt2", bus2.swap_cnt, 0);
      check("rst_case8", bus8.case_id, 0);      check("rst_case2", bus2.case_id, 0);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b1; en = 1'b0; clr_err = 1'b0;
      #1 check_zero();
      q.delete();
      model_reset();
      osc = 2'b01; osc_a = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every registered output is valid one step after each stimulus edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && q.size() > 0) begin
            x = q.pop_front();
            check("locked8", bus8.locked, x.locked);       check("locked2", bus2.locked, x.locked);
            check("pulse8", bus8.err_pulse, x.pulse);      check("pulse2", bus2.err_pulse, x.pulse);
            check("sticky8", bus8.err_sticky, x.sticky);   check("sticky2", bus2.err_sticky, x.sticky);
            check("errcnt8", bus8.err_cnt, (x.errs > 255) ? 255 : x.errs);
            check("errcnt2", bus2.err_cnt, (x.errs > 3) ? 3 : x.errs);
            check("swapcnt8", bus8.swap_cnt, x.swaps % 256);
            check("swapcnt2", bus2.swap_cnt, x.swaps % 4);
            check("case8", bus8.case_id, x.case_id);       check("case2", bus2.case_id, x.case_id);
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; a_in = 1'b0; state_in = 2'b00; clr_err = 1'b0;
      model_reset();
      osc = 2'b01; osc_a = 1'b0;
      repeat (2) @(negedge clk);
      check_zero();
      rst = 1'b0;

      // Lock on 00,01,00,01,00.
      repeat (5) osc_step(1, 0, 0, 0);
      #1 check("t1_locked", bus8.locked, 1);
      // One case swap 01 -> 11.
      osc_step(1, 1, 0, 0);
      osc_step(1, 0, 0, 0);
      #1 check("t2_swap", bus8.swap_cnt, 1);
      check("t2_case", bus8.case_id, 1);
      // Glitch to 00 where 10 is legal.
      osc_step(1, 0, 1, 0);
      #1 check("t3_pulse", bus8.err_pulse, 1);
      check("t3_errcnt", bus8.err_cnt, 1);
      check("t3_locked", bus8.locked, 0);
      repeat (5) osc_step(1, 0, 0, 0);
      #1 check("t3_relock", bus8.locked, 1);
      // Saturation and wrap on the narrow instance.
      for (int i = 0; i < 5; i++) begin
         osc_step(1, 0, 1, 0);
         repeat (5) osc_step(1, 0, 0, 0);
      end
      for (int i = 0; i < 5; i++) begin
         osc_step(1, 1, 0, 0);
         osc_step(1, 0, 0, 0);
      end
      #1 check("t4_errsat2", bus2.err_cnt, 3);
      check("t4_err8", bus8.err_cnt, 6);
      check("t4_swapwrap2", bus2.swap_cnt, 2);
      // Clear collides with a fresh error.
      osc_step(1, 0, 1, 1);
      #1 check("t5_errcnt", bus8.err_cnt, 1);
      check("t5_sticky", bus8.err_sticky, 1);
      repeat (5) osc_step(1, 0, 0, 0);
      // Enable drop forces re-acquisition; counters hold.
      repeat (2) osc_step(0, 0, 0, 0);
      #1 check("t6_unlocked", bus8.locked, 0);
      check("t6_swapheld", bus8.swap_cnt, 6);
      repeat (4) osc_step(1, 0, 0, 0);
      #1 check("t6_notyet", bus8.locked, 0);
      osc_step(1, 0, 0, 0);
      #1 check("t6_relock", bus8.locked, 1);
      repeat (3) osc_step(1, 1, 0, 0);
      async_reset();

      // Randomised run with one mid-run async reset.
      for (int i = 0; i < 1500; i++) begin
         if (i == 800) async_reset();
         osc_step($urandom_range(0, 29) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);
      end

      repeat (2) @(negedge clk);
      check("drain", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
